// File: rtl/unified_memory.sv
// Word/byte-mapped unified instruction+data memory with a fixed number of wait states.
// Storage holds (word ^ preload image), so a zero-initialised array presents the preload pattern.
module unified_memory #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 2048,
  parameter int INST_BASE   = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic                we,
  input  logic [31:0]         addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] be,
  output logic                ready,
  output logic                done,
  output logic                rvalid,
  output logic [DATA_W-1:0]   rdata,
  output logic                err
);

  localparam int NB = DATA_W / 8;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WLOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic [DATA_W-1:0] mem [DEPTH];

  // Request captured at the accepting edge
  logic              we_p0;
  logic [31:0]       addr_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic [NB-1:0]     be_p0;

  logic              op_we, op_ok, go;
  logic [31:0]       op_addr, op_idx;
  logic [DATA_W-1:0] op_wdata, op_pre;
  logic [NB-1:0]     op_be;

  function automatic logic [31:0] map_index(input logic [31:0] a);
    if (a < 32'(INST_BASE)) return a;
    return ((a - 32'(INST_BASE)) >> 2) + 32'(INST_BASE);
  endfunction

  function automatic logic [DATA_W-1:0] preload_word(input logic [31:0] idx);
    return (idx < 32'(INST_BASE)) ? DATA_W'(idx) : '0;
  endfunction

  assign ready = (state == IDLE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (req) begin
          if (WAIT_CYCLES > 0) begin
            state_nxt = WAIT;
            cnt_nxt   = WLOAD;
          end else begin
            state_nxt = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_nxt = RESP;
        else             cnt_nxt   = cnt - 4'd1;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // With no wait states the access completes on the accepting edge, so use the live inputs
  always_comb begin
    op_we    = (state == IDLE) ? we    : we_p0;
    op_addr  = (state == IDLE) ? addr  : addr_p0;
    op_wdata = (state == IDLE) ? wdata : wdata_p0;
    op_be    = (state == IDLE) ? be    : be_p0;
    op_idx   = map_index(op_addr);
    op_ok    = (op_idx < 32'(DEPTH));
    op_pre   = preload_word(op_idx);
    go       = (state_nxt == RESP) && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      done   <= 1'b0;
      rvalid <= 1'b0;
      err    <= 1'b0;
      rdata  <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      done   <= go;
      rvalid <= go && !op_we;
      err    <= go && !op_ok;
      if (go && !op_we)
        rdata <= op_ok ? (mem[op_idx[AW-1:0]] ^ op_pre) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      we_p0    <= we;
      addr_p0  <= addr;
      wdata_p0 <= wdata;
      be_p0    <= be;
    end
  end

  // Commit point: the edge entering RESP
  always_ff @(posedge clk) begin
    if (go && op_we && op_ok) begin
      for (int i = 0; i < NB; i++) begin
        if (op_be[i])
          mem[op_idx[AW-1:0]][8*i +: 8] <= op_wdata[8*i +: 8] ^ op_pre[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_unified_memory.sv
// Scoreboard bench for unified_memory: a 2-wait-state instance and a zero-wait instance.
module tb_unified_memory;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic        ready, done, rvalid, err;
  logic [31:0] rdata;

  logic        req0, we0;
  logic [31:0] addr0, wdata0;
  logic [3:0]  be0;
  logic        ready0, done0, rvalid0, err0;
  logic [31:0] rdata0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          rd;
    bit          er;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        sb0[$];
  logic [31:0] ref_mem [0:2047];
  logic [31:0] last_rd;
  int          done0_cnt;

  always #5 clk = ~clk;

  unified_memory #(.DATA_W(32), .DEPTH(2048), .INST_BASE(1024), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .ready(ready), .done(done), .rvalid(rvalid), .rdata(rdata), .err(err)
  );

  unified_memory #(.DATA_W(32), .DEPTH(2048), .INST_BASE(1024), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0), .be(be0),
    .ready(ready0), .done(done0), .rvalid(rvalid0), .rdata(rdata0), .err(err0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned tb_index(input logic [31:0] a);
    if (a < 32'd1024) return a;
    return (a - 32'd1024) / 4 + 1024;
  endfunction

  function automatic logic [31:0] tb_preload(input int unsigned idx);
    return (idx < 1024) ? idx : 32'd0;
  endfunction

  // Completion monitors
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", done, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rvalid", rvalid, e.rd);
        chk("err", err, e.er);
        if (e.rd) last_rd = e.data;
        chk(e.rd ? "rdata" : "rdata_hold", rdata, last_rd);
      end
    end
  end

  always @(negedge clk) begin
    if (done0) begin
      done0_cnt++;
      if (sb0.size() == 0) begin
        chk("w0_unexpected_done", done0, 1'b0);
      end else begin
        exp_t e;
        e = sb0.pop_front();
        chk("w0_rvalid", rvalid0, e.rd);
        chk("w0_err", err0, e.er);
        chk("w0_rdata", rdata0, e.data);
      end
    end
  end

  task automatic push_expect(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] b);
    int unsigned idx;
    bit inr;
    exp_t e;
    idx = tb_index(a);
    inr = (idx < 2048);
    e.rd = !w;
    e.er = !inr;
    e.data = 32'd0;
    if (w) begin
      if (inr)
        for (int i = 0; i < 4; i++)
          if (b[i]) ref_mem[idx][8*i +: 8] = d[8*i +: 8];
    end else if (inr) begin
      e.data = ref_mem[idx];
    end
    sb.push_back(e);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready) chk("ready_timeout", ready, 1'b1);
  endtask

  // One access on the 2-wait instance; checks completion latency and ready timing.
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b);
    int n;
    @(negedge clk);
    wait_ready();
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    push_expect(w, a, d, b);
    @(posedge clk);
    #1;
    req = 1'b0; we = $urandom_range(0, 1); addr = $urandom; wdata = $urandom; be = 4'hF;
    n = 1;
    while (!done && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", n, 3);
    chk("ready_in_resp", ready, 1'b0);
    @(posedge clk);
    #1;
    chk("ready_after", ready, 1'b1);
  endtask

  initial begin
    logic [6:0] pat;
    int acc0;
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] pat;
    int acc0;
    for (int i = 0; i < 2048; i++) ref_mem[i] = tb_preload(i);
    last_rd = 32'd0;
    done0_cnt = 0;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0; be0 = '0;

    // Reset with req held high: nothing may be accepted
    rst = 1'b1;
    req = 1'b1; req0 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", ready, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_done0", done0, 1'b0);
    @(negedge clk);
    req = 1'b0; req0 = 1'b0;
    rst = 1'b0;
    repeat (6) @(negedge clk);

    // Basic read, byte-enabled write, read-after-write
    access(1'b0, 32'd1, 32'd0, 4'h0);
    access(1'b1, 32'd5, 32'hAABBCCDD, 4'b0101);
    access(1'b0, 32'd5, 32'd0, 4'h0);

    // Instruction region, byte-addressed
    access(1'b0, 32'd1032, 32'd0, 4'h0);
    access(1'b1, 32'd1032, 32'h8C010001, 4'hF);
    for (int a = 1032; a < 1036; a++) access(1'b0, a, 32'd0, 4'h0);
    access(1'b0, 32'd1031, 32'd0, 4'h0);
    access(1'b0, 32'd1036, 32'd0, 4'h0);

    // Out of range, then the aliasing candidate must be untouched
    access(1'b0, 32'h0000FFFF, 32'd0, 4'h0);
    access(1'b1, 32'h0000FFFF, 32'h12345678, 4'hF);
    access(1'b0, 32'd767, 32'd0, 4'h0);
    access(1'b0, 32'd2047, 32'd0, 4'h0);

    // be=0 write changes nothing
    access(1'b1, 32'd9, 32'hFFFFFFFF, 4'h0);
    access(1'b0, 32'd9, 32'd0, 4'h0);

    // Reset during WAIT aborts the write
    @(negedge clk);
    wait_ready();
    req = 1'b1; we = 1'b1; addr = 32'd7; wdata = 32'hDEADBEEF; be = 4'hF;
    @(posedge clk);
    #1;
    req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_ready", ready, 1'b1);
    chk("abort_done", done, 1'b0);
    chk("abort_rdata", rdata, 32'd0);
    last_rd = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    access(1'b0, 32'd7, 32'd0, 4'h0);

    // Random mix over a few hot words in both regions
    for (int k = 0; k < 16; k++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 15)) : 32'($urandom_range(1024, 1060));
      access(1'b1 & $urandom_range(0, 1), a, $urandom, 4'($urandom_range(0, 15)));
    end

    // Zero-wait instance: req held for 6 cycles
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd3; be0 = 4'h0; wdata0 = 32'd0;
    pat = '0;
    acc0 = 0;
    done0_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      pat[i] = done0;
      if (ready0) begin
        exp_t e;
        e.rd = 1'b1;
        e.er = 1'b0;
        e.data = tb_preload(tb_index(addr0));
        sb0.push_back(e);
        acc0++;
      end
      @(negedge clk);
    end
    pat[6] = done0;
    req0 = 1'b0;
    repeat (4) @(negedge clk);
    chk("w0_accepts", acc0, 3);
    chk("w0_done_pattern", pat, 7'b0101010);
    chk("w0_completions", done0_cnt, 3);

    repeat (4) @(negedge clk);
    chk("sb_drain", sb.size(), 0);
    chk("sb0_drain", sb0.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
